// File: rtl/ifu_lsu_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define ARB_TIMEOUT_EN to end a stalled WAIT with an error response after TIMEOUT_CYCLES.
module ifu_lsu_arbiter #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   // fetch side
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_req_addr,
   output logic        ifu_rsp_valid,
   input  logic        ifu_rsp_ready,
   output logic [31:0] ifu_rsp_data,
   output logic        ifu_rsp_err,
   // load/store side
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_req_addr,
   input  logic        lsu_req_wen,
   input  logic [31:0] lsu_req_wdata,
   input  logic [7:0]  lsu_req_wmask,
   input  logic [2:0]  lsu_req_len,
   output logic        lsu_rsp_valid,
   input  logic        lsu_rsp_ready,
   output logic [31:0] lsu_rsp_rdata,
   output logic        lsu_rsp_err,
   // memory side
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   output logic [2:0]  mem_len,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("STARVE_LIMIT out of range 1..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES out of range 1..65535");
   end

   state_t      state, state_nxt;
   logic        owner_lsu;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        wen_q;
   logic [7:0]  wmask_q;
   logic [2:0]  len_q;
   logic [3:0]  starve_cnt;
   logic        lsu_win, ifu_win, timeout_hit;

   // LSU has priority unless IFU has been passed over STARVE_LIMIT times in a row.
   assign lsu_win = lsu_req_valid && !(starve_cnt == STARVE_MAX && ifu_req_valid);
   assign ifu_win = ifu_req_valid && !lsu_win;

   assign lsu_req_ready = (state == S_IDLE) && lsu_win;
   assign ifu_req_ready = (state == S_IDLE) && ifu_win;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt;
   logic        err_q;

   assign timeout_hit = (state == S_WAIT) && (wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         // Clearing throughout ISSUE means the count starts at zero on WAIT entry.
         if (state == S_ISSUE)
            wait_cnt <= '0;
         else if (state == S_WAIT)
            wait_cnt <= wait_cnt + 16'd1;
         if (state == S_WAIT && (mem_rsp_valid || timeout_hit))
            err_q <= !mem_rsp_valid;
      end
   end

   assign ifu_rsp_err = (state == S_RESP) && !owner_lsu && err_q;
   assign lsu_rsp_err = (state == S_RESP) &&  owner_lsu && err_q;
`else
   assign timeout_hit = 1'b0;
   assign ifu_rsp_err = 1'b0;
   assign lsu_rsp_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (lsu_win || ifu_win)             state_nxt = S_ISSUE;
         S_ISSUE: if (mem_req_ready)                  state_nxt = S_WAIT;
         S_WAIT:  if (mem_rsp_valid || timeout_hit)   state_nxt = S_RESP;
         S_RESP:  if (owner_lsu ? lsu_rsp_ready : ifu_rsp_ready)
                                                      state_nxt = S_IDLE;
         default:                                     state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_lsu  <= 1'b0;
         addr_q     <= '0;
         wen_q      <= 1'b0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         len_q      <= '0;
         rdata_q    <= '0;
         starve_cnt <= '0;
      end else begin
         if (state == S_IDLE && lsu_win) begin
            owner_lsu <= 1'b1;
            addr_q    <= lsu_req_addr;
            wen_q     <= lsu_req_wen;
            wdata_q   <= lsu_req_wdata;
            wmask_q   <= lsu_req_wmask;
            len_q     <= lsu_req_len;
            if (ifu_req_valid && starve_cnt != STARVE_MAX)
               starve_cnt <= starve_cnt + 4'd1;
         end else if (state == S_IDLE && ifu_win) begin
            owner_lsu  <= 1'b0;
            addr_q     <= ifu_req_addr;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            len_q      <= 3'd4;
            starve_cnt <= '0;
         end
         if (state == S_WAIT && mem_rsp_valid)
            rdata_q <= wen_q ? 32'h0 : mem_rsp_rdata;
         else if (timeout_hit)
            rdata_q <= '0;
      end
   end

   assign mem_req_valid = (state == S_ISSUE);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;
   assign mem_len       = len_q;

   assign ifu_rsp_valid = (state == S_RESP) && !owner_lsu;
   assign lsu_rsp_valid = (state == S_RESP) &&  owner_lsu;
   assign ifu_rsp_data  = rdata_q;
   assign lsu_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ifu_lsu_arbiter.sv
// Directed bench for ifu_lsu_arbiter: fetch, store, starvation order, stalled response,
// mid-transaction reset and WAIT timeout (ARB_TIMEOUT_EN) with hand-computed expectations.
module tb_ifu_lsu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
   logic [31:0] ifu_req_addr, ifu_rsp_data;
   logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready, lsu_rsp_err;
   logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
   logic [7:0]  lsu_req_wmask;
   logic [2:0]  lsu_req_len;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
   logic [7:0]  mem_wmask;
   logic [2:0]  mem_len;

   int n_checks = 0;
   int n_errors = 0;

   ifu_lsu_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
      .ifu_rsp_err(ifu_rsp_err),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
      .lsu_req_len(lsu_req_len),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
      .lsu_rsp_err(lsu_rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_len(mem_len),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      ifu_req_valid = 0; ifu_req_addr = 0; ifu_rsp_ready = 1;
      lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0;
      lsu_req_wmask = 0; lsu_req_len = 0; lsu_rsp_ready = 1;
      mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_rdata = 0;
      step(); step();

      // Reset state
      check("rst_mem_req_valid", 32'(mem_req_valid), 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_len", 32'(mem_len), 0);
      check("rst_rsp_valids", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 0);
      check("rst_rsp_data", ifu_rsp_data, 0);
      reset = 1'b0;
      step();

      // 1. Single IFU read, best-case latency
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
      #1 check("t1_ifu_ready", 32'(ifu_req_ready), 1);
      check("t1_lsu_ready", 32'(lsu_req_ready), 0);
      step();                                   // accept edge (cycle N)
      ifu_req_valid = 0;
      check("t1_issue_valid", 32'(mem_req_valid), 1);
      check("t1_issue_addr", mem_addr, 32'h8000_0000);
      check("t1_issue_len_wen", {28'd0, mem_len, mem_wen}, {28'd0, 3'd4, 1'b0});
      check("t1_ifu_ready_busy", 32'(ifu_req_ready), 0);
      step();                                   // now WAIT
      mem_rsp_valid = 1; mem_rsp_rdata = 32'h0010_0073;
      check("t1_wait_no_rsp", 32'(ifu_rsp_valid), 0);
      step();                                   // now RESP
      mem_rsp_valid = 0;
      check("t1_ifu_rsp_valid", 32'(ifu_rsp_valid), 1);
      check("t1_ifu_rsp_data", ifu_rsp_data, 32'h0010_0073);
      check("t1_ifu_rsp_err", 32'(ifu_rsp_err), 0);
      check("t1_lsu_rsp_valid", 32'(lsu_rsp_valid), 0);
      step();                                   // back in IDLE
      check("t1_idle_rsp_valid", 32'(ifu_rsp_valid), 0);
      check("t1_idle_mem_valid", 32'(mem_req_valid), 0);

      // 2. LSU byte store held across 3 cycles of mem_req_ready=0
      mem_req_ready = 0;
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
      lsu_req_wdata = 32'h0000_00AB; lsu_req_wmask = 8'h01; lsu_req_len = 3'd1;
      step();
      lsu_req_valid = 0; lsu_req_wen = 0;
      for (int i = 0; i < 3; i++) begin
         check("t2_hold_valid", 32'(mem_req_valid), 1);
         check("t2_hold_wen_mask", {23'd0, mem_wen, mem_wmask}, {23'd0, 1'b1, 8'h01});
         check("t2_hold_wdata", mem_wdata, 32'h0000_00AB);
         check("t2_hold_addr", mem_addr, 32'h8000_1000);
         step();
      end
      check("t2_still_issue", 32'(mem_req_valid), 1);
      mem_req_ready = 1;
      step();                                   // WAIT
      mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEAD_BEEF;
      step();                                   // RESP
      mem_rsp_valid = 0;
      check("t2_lsu_rsp_valid", 32'(lsu_rsp_valid), 1);
      check("t2_lsu_rsp_rdata", lsu_rsp_rdata, 0);
      check("t2_ifu_rsp_valid", 32'(ifu_rsp_valid), 0);
      step();                                   // IDLE

      // 3. Both requesters continuously valid: L,L,L,L,I repeating
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0100;
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_2000; lsu_req_len = 3'd4;
      mem_rsp_valid = 1; mem_rsp_rdata = 32'hCAFE_F00D;   // ignored outside WAIT
      #1;
      for (int i = 0; i < 10; i++) begin
         logic exp_lsu;
         exp_lsu = (i % 5) != 4;
         check($sformatf("t3_grant%0d_lsu", i), 32'(lsu_req_ready), 32'(exp_lsu));
         check($sformatf("t3_grant%0d_ifu", i), 32'(ifu_req_ready), 32'(!exp_lsu));
         step(); step(); step();                  // ISSUE, WAIT, RESP
         check($sformatf("t3_rsp%0d_owner", i), {30'd0, lsu_rsp_valid, ifu_rsp_valid},
               exp_lsu ? 32'd2 : 32'd1);
         check($sformatf("t3_rsp%0d_data", i), lsu_rsp_rdata, 32'hCAFE_F00D);
         step();                                  // IDLE
      end
      lsu_req_valid = 0;

      // 4. LSU response stalled 5 cycles with IFU waiting
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_3002; lsu_req_len = 3'd2;
      lsu_rsp_ready = 0; mem_rsp_rdata = 32'h0BAD_C0DE;
      #1 check("t4_lsu_wins", {30'd0, lsu_req_ready, ifu_req_ready}, 32'd2);
      step();
      lsu_req_valid = 0;
      step(); step();                             // WAIT, RESP
      for (int i = 0; i < 5; i++) begin
         check("t4_stall_valid", 32'(lsu_rsp_valid), 1);
         check("t4_stall_data", lsu_rsp_rdata, 32'h0BAD_C0DE);
         check("t4_stall_readys", {30'd0, lsu_req_ready, ifu_req_ready}, 0);
         step();
      end
      lsu_rsp_ready = 1;
      check("t4_release_valid", 32'(lsu_rsp_valid), 1);
      step();                                     // IDLE
      check("t4_single_grant", {30'd0, lsu_req_ready, ifu_req_ready}, 32'd1);
      mem_rsp_rdata = 32'h0000_0013;
      step();
      ifu_req_valid = 0;
      check("t4_ifu_addr", mem_addr, 32'h8000_0100);
      step(); step();
      check("t4_ifu_rsp", {31'd0, ifu_rsp_valid}, 1);
      check("t4_ifu_data", ifu_rsp_data, 32'h0000_0013);
      step();

      // 5. Reset asserted in WAIT, then a stray memory response
      mem_rsp_valid = 0;
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010;
      step();
      ifu_req_valid = 0;
      step();                                     // WAIT
      reset = 1;
      #1;
      check("t5_rst_mem_valid", 32'(mem_req_valid), 0);
      check("t5_rst_mem_addr", mem_addr, 0);
      check("t5_rst_mem_len", 32'(mem_len), 0);
      check("t5_rst_data", ifu_rsp_data, 0);
      step();
      reset = 0;
      mem_rsp_valid = 1; mem_rsp_rdata = 32'h1111_1111;
      step();
      mem_rsp_valid = 0;
      for (int i = 0; i < 3; i++) begin
         check("t5_no_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 0);
         check("t5_no_issue", 32'(mem_req_valid), 0);
         step();
      end
      ifu_req_valid = 1; ifu_req_addr = 32'h8000_0020;
      step();
      ifu_req_valid = 0;
      check("t5_next_addr", mem_addr, 32'h8000_0020);
      step();
      mem_rsp_valid = 1; mem_rsp_rdata = 32'h0000_0093;
      step();
      mem_rsp_valid = 0;
      check("t5_next_rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd2);
      check("t5_next_data", ifu_rsp_data, 32'h0000_0093);
      step();

      // 6. Memory silent in WAIT
      lsu_req_valid = 1; lsu_req_addr = 32'h8000_4000; lsu_req_len = 3'd4;
      step();
      lsu_req_valid = 0;
      step();                                     // first WAIT cycle
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 7; i++) step();
      check("t6_before_timeout", 32'(lsu_rsp_valid), 0);
      step();
      check("t6_timeout_valid", 32'(lsu_rsp_valid), 1);
      check("t6_timeout_err", 32'(lsu_rsp_err), 1);
      check("t6_timeout_rdata", lsu_rsp_rdata, 0);
      step();
`else
      for (int i = 0; i < 1000; i++) step();
      lsu_req_valid = 1;
      #1;
      check("t6_still_wait_rsp", {30'd0, lsu_rsp_valid, ifu_rsp_valid}, 0);
      check("t6_still_wait_busy", {30'd0, lsu_req_ready, mem_req_valid}, 0);
      check("t6_err_tied", {30'd0, lsu_rsp_err, ifu_rsp_err}, 0);
      lsu_req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_rdata = 32'h5555_AAAA;
      step();
      mem_rsp_valid = 0;
      check("t6_late_rsp", lsu_rsp_rdata, 32'h5555_AAAA);
      step();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ifu_lsu_arbiter.md
# ifu_lsu_arbiter

Arbitrates the core's single physical memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write). Sequences one transaction at a time through a four-state FSM with valid/ready handshakes on every side. LSU has fixed priority, with a starvation counter that bounds IFU wait. Sits between the fetch/LSU stages of `npc` and the memory backend (`v_pmem_read`/`v_pmem_write` wrapper).

## Interface
- `STARVE_LIMIT`, 4: consecutive LSU grants with IFU pending before IFU is forced next (1..15).
- `TIMEOUT_CYCLES`, 255: WAIT-state cycles before error response (used only with `ARB_TIMEOUT_EN`, 1..65535).

- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_req_addr` in 32: fetch request, always a 4-byte read.
- `ifu_rsp_valid` out 1 / `ifu_rsp_ready` in 1 / `ifu_rsp_data` out 32 / `ifu_rsp_err` out 1: fetch response.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1 / `lsu_req_addr` in 32 / `lsu_req_wen` in 1 / `lsu_req_wdata` in 32 / `lsu_req_wmask` in 8 / `lsu_req_len` in 3: LSU request; `len` in bytes (1, 2, 4) for reads.
- `lsu_rsp_valid` out 1 / `lsu_rsp_ready` in 1 / `lsu_rsp_rdata` out 32 / `lsu_rsp_err` out 1: LSU response; writes also get one (rdata 0).
- `mem_req_valid` out 1 / `mem_req_ready` in 1 / `mem_addr` out 32 / `mem_wen` out 1 / `mem_wdata` out 32 / `mem_wmask` out 8 / `mem_len` out 3: memory request.
- `mem_rsp_valid` in 1 / `mem_rsp_rdata` in 32: memory response; one per accepted request, write included.

## Operation
- FSM: IDLE, ISSUE, WAIT, RESP. Reset → IDLE.
- IDLE: choose winner combinationally. LSU wins if `lsu_req_valid`, unless `starve_cnt == STARVE_LIMIT` and `ifu_req_valid`, then IFU. Only winner's `*_req_ready` = 1. On handshake latch addr/wen/wdata/wmask/len and owner bit; go ISSUE. IFU request latched as wen=0, wmask=0, len=4.
- `starve_cnt` (4-bit): +1 on each LSU grant while `ifu_req_valid`=1, saturates at `STARVE_LIMIT`; cleared on IFU grant.
- ISSUE: `mem_req_valid`=1 with latched payload, held stable until `mem_req_ready`; then WAIT.
- WAIT: on `mem_rsp_valid` capture `mem_rsp_rdata` (writes capture 0), err=0; go RESP.
- RESP: owner's `*_rsp_valid`=1, data/err stable; on owner's `*_rsp_ready` → IDLE. Non-owner rsp_valid stays 0.
- `mem_rsp_valid` outside WAIT is ignored (no state change, no data captured).
- rdata passed unmodified; byte/half extraction and extension are the LSU's job.
- Both `*_req_ready` are 0 outside IDLE; requesters hold requests until accepted.

## Timing
- Reset values: all `*_ready`, `*_valid`, `*_err` outputs 0; `mem_addr`, `mem_wdata`, `mem_wmask`, `mem_len`, `mem_wen`, rsp data 0; `starve_cnt` 0.
- Best case (`mem_req_ready`=1 on first ISSUE cycle, `mem_rsp_valid` next cycle, `rsp_ready`=1): accept cycle N, `mem_req_valid` N+1, `mem_rsp_valid` N+2, `*_rsp_valid` N+3, back in IDLE N+4. Peak throughput one transaction per 4 cycles.
- All outputs registered or decoded from FSM state only, except `*_req_ready` (state plus request valids).
- Simultaneous valid requests at IDLE: exactly one grant per cycle, never both.
- Async reset mid-transaction: immediate return to IDLE, transaction dropped, no response issued; a late `mem_rsp_valid` after reset is ignored per the WAIT rule.

## Configuration
- `ARB_TIMEOUT_EN` defined: a 16-bit counter clears on WAIT entry and increments each WAIT cycle. At `TIMEOUT_CYCLES` without `mem_rsp_valid` → RESP with err=1, rdata=0. `mem_rsp_valid` in the same cycle as expiry wins (err=0). Later responses are ignored.
- Not defined: WAIT waits indefinitely; `ifu_rsp_err`/`lsu_rsp_err` tied 0; no counter logic.

## Test plan
- Single IFU read addr 0x80000000, memory returns 0x00100073 one cycle after accept -> `ifu_rsp_valid` at accept+3 with data 0x00100073, err 0, `lsu_rsp_valid` never high.
- LSU sb to 0x80001000, wdata 0x000000AB, wmask 0x01 -> `mem_wen`=1, `mem_wmask`=0x01, `mem_wdata`=0xAB held through 3 cycles of `mem_req_ready`=0; `lsu_rsp_valid` with rdata 0.
- Both requesters valid continuously, `STARVE_LIMIT`=4 -> grant order LSU,LSU,LSU,LSU,IFU, repeating.
- `lsu_rsp_ready` held 0 for 5 cycles in RESP -> rsp_valid/data stable, both `*_req_ready` 0, single grant after release.
- Assert `reset` in WAIT, then `mem_rsp_valid` pulse after release -> outputs at reset values, no response to either requester, next IFU request completes normally.
- With `ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, memory silent -> `lsu_rsp_valid` with err 1, rdata 0 after 8 WAIT cycles; without the macro, still in WAIT after 1000 cycles.
